// File: rtl/fp_mac_sequencer.sv
// fp_mac_sequencer
// Control sequencer for a pipelined floating-point multiply-accumulate unit
// that computes a dot product of 'len' operand pairs.
//   - Accepts operand pairs in RUN, drives per-stage enables from a valid
//     shift register, and tags the first pair so that the accumulator loads
//     it instead of adding it.
//   - Waits in DRAIN until the pipeline is empty, then holds the result in
//     DONE until the consumer takes it.
// Optional feature: define FP_MAC_SEQ_OVF_FLAG_EN to enable the sticky
// per-job overflow flag (ov_flag). Without it, ov_flag is tied to 0.

module fp_mac_sequencer #(
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      len,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PIPE_DEPTH-1:0] stage_en,
    output logic                  acc_en,
    output logic                  acc_clear,
    input  logic                  ov_sign_in,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  ov_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PIPE_DEPTH-1:0] VLD_ZERO = {PIPE_DEPTH{1'b0}};

    state_t                  state_r;
    state_t                  state_s;
    logic [CNT_W-1:0]        len_r;
    logic [CNT_W-1:0]        issued_r;
    logic [PIPE_DEPTH-1:0]   vld_r;
    logic [PIPE_DEPTH-1:0]   tag_r;

    logic                    run_open_s;
    logic                    accept_s;
    logic                    start_ok_s;
    logic                    last_s;
    logic                    first_s;
    logic                    acc_en_s;

    // Handshake decode: which inputs are honoured in the current state.
    // Every output is forced low while reset is asserted so the downstream
    // pipeline never sees an enable during reset.
    always_comb begin
        run_open_s = 1'b0;
        accept_s   = 1'b0;
        start_ok_s = 1'b0;
        last_s     = 1'b0;
        first_s    = 1'b0;
        if (reset) begin
            run_open_s = 1'b0;
        end else begin
            run_open_s = (state_r == RUN) && (issued_r < len_r);
        end
        accept_s   = in_valid & run_open_s;
        start_ok_s = (~reset) & (state_r == IDLE) & start & (len != CNT_ZERO);
        last_s     = accept_s & ((issued_r + CNT_ONE) == len_r);
        first_s    = accept_s & (issued_r == CNT_ZERO);
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (vld_r == VLD_ZERO) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode: enables follow the valid/tag shift registers directly.
    always_comb begin
        in_ready  = run_open_s;
        acc_en_s  = vld_r[PIPE_DEPTH-1] & ~reset;
        acc_en    = acc_en_s;
        acc_clear = acc_en_s & tag_r[PIPE_DEPTH-1];
        stage_en  = {vld_r[PIPE_DEPTH-2:0], accept_s} & {PIPE_DEPTH{~reset}};
        busy      = (state_r != IDLE) & ~reset;
        res_valid = (state_r == DONE) & ~reset;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job length, issue counter and the valid/first-tag pipeline shadows.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_r    <= CNT_ZERO;
            issued_r <= CNT_ZERO;
            vld_r    <= VLD_ZERO;
            tag_r    <= VLD_ZERO;
        end else begin
            if (start_ok_s) begin
                len_r    <= len;
                issued_r <= CNT_ZERO;
            end else if (accept_s) begin
                issued_r <= issued_r + CNT_ONE;
            end else begin
                issued_r <= issued_r;
            end
            vld_r <= {vld_r[PIPE_DEPTH-2:0], accept_s};
            tag_r <= {tag_r[PIPE_DEPTH-2:0], first_s};
        end
    end

`ifdef FP_MAC_SEQ_OVF_FLAG_EN
    logic ov_r;

    // Sticky overflow: cleared when a job starts, set by an overflowing accumulate.
    always_ff @(posedge clock) begin
        if (reset) begin
            ov_r <= 1'b0;
        end else if (start_ok_s) begin
            ov_r <= 1'b0;
        end else if (acc_en_s & ov_sign_in) begin
            ov_r <= 1'b1;
        end else begin
            ov_r <= ov_r;
        end
    end

    assign ov_flag = ov_r & ~reset;
`else
    logic unused_ov_sign_in;

    assign unused_ov_sign_in = ov_sign_in;
    assign ov_flag           = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Directed bench for fp_mac_sequencer with a scoreboard: every accepted
// operand pair pushes an expected accumulator event (due cycle, clear bit),
// every last accept pushes an expected result cycle; both are popped as the
// DUT is expected to produce them.
module tb_fp_mac_sequencer;

    localparam int P  = 5;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [P-1:0]  stage_en;
    logic          acc_en;
    logic          acc_clear;
    logic          ov_sign_in;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic          ov_flag;

    fp_mac_sequencer #(.PIPE_DEPTH(P), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .stage_en   (stage_en),
        .acc_en     (acc_en),
        .acc_clear  (acc_clear),
        .ov_sign_in (ov_sign_in),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .ov_flag    (ov_flag)
    );

    always #5 clock = ~clock;

    typedef struct {
        int due;
        bit clr;
    } acc_t;

    typedef enum int {M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3} mstate_t;

    acc_t    acc_q[$];
    int      res_q[$];
    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    mstate_t m_state = M_IDLE;
    int      m_len = 0;
    int      m_issued = 0;
    bit      m_first = 1'b0;
    bit      m_ov = 1'b0;
    int      pulse_cnt = 0;
    int      ov_mode = 0;
    int      ov_pulse = -1;
    int      done_entries = 0;
    int      rv_rises = 0;
    bit      prev_rv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: starts just after a falling edge with inputs applied.
    task automatic cycle();
        bit acc_now, accept, e_rdy, e_busy, e_rv, e_clr, e_last, e_ov;
        acc_now = !reset && (acc_q.size() > 0) && (acc_q[0].due == cyc);
        case (ov_mode)
            1:       ov_sign_in = acc_now && (pulse_cnt == ov_pulse);
            2:       ov_sign_in = !acc_now;
            default: ov_sign_in = 1'b0;
        endcase
        #1;
        e_rdy  = !reset && (m_state == M_RUN) && (m_issued < m_len);
        accept = e_rdy && in_valid;
        e_busy = !reset && (m_state != M_IDLE);
        e_rv   = !reset && (m_state == M_DONE);
        e_clr  = acc_now && acc_q[0].clr;
        e_last = 1'b0;
        foreach (acc_q[i]) if (acc_q[i].due == cyc + 1) e_last = !reset;
`ifdef FP_MAC_SEQ_OVF_FLAG_EN
        e_ov = !reset && m_ov;
`else
        e_ov = 1'b0;
`endif
        chk("in_ready",  in_ready,      e_rdy);
        chk("busy",      busy,          e_busy);
        chk("res_valid", res_valid,     e_rv);
        chk("acc_en",    acc_en,        acc_now);
        chk("acc_clear", acc_clear,     e_clr);
        chk("stage_en0", stage_en[0],   accept);
        chk("stage_enN", stage_en[P-1], e_last);
        chk("ov_flag",   ov_flag,       e_ov);
        if (res_valid === 1'b1 && !prev_rv) rv_rises++;
        prev_rv = (res_valid === 1'b1);

        if (acc_now) begin
            void'(acc_q.pop_front());
            if (ov_sign_in) m_ov = 1'b1;
            pulse_cnt++;
        end
        if (reset) begin
            m_state  = M_IDLE;
            m_issued = 0;
            m_ov     = 1'b0;
            acc_q.delete();
            res_q.delete();
        end else begin
            case (m_state)
                M_IDLE: if (start && len != 0) begin
                    m_state   = M_RUN;
                    m_len     = len;
                    m_issued  = 0;
                    m_first   = 1'b1;
                    m_ov      = 1'b0;
                    pulse_cnt = 0;
                end
                M_RUN: if (accept) begin
                    acc_q.push_back('{due: cyc + P, clr: m_first});
                    m_first = 1'b0;
                    m_issued++;
                    if (m_issued == m_len) begin
                        res_q.push_back(cyc + P + 2);
                        m_state = M_DRAIN;
                    end
                end
                M_DRAIN: if (res_q.size() > 0 && res_q[0] == cyc + 1) begin
                    void'(res_q.pop_front());
                    m_state = M_DONE;
                    done_entries++;
                end
                M_DONE: if (res_ready) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic run_until(input mstate_t target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_state == target) break;
            cycle();
        end
        chk("state_bound", m_state, target);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        res_ready = 1'b0; ov_sign_in = 1'b0;
        @(negedge clock);
        cycle(); cycle();
        reset = 1'b0;
        cycle();

        // len=3, in_valid held high, overflow on the 2nd accumulate
        ov_mode = 1; ov_pulse = 1;
        in_valid = 1'b1; start = 1'b1; len = 8'd3;
        cycle();
        start = 1'b0;
        run_until(M_DONE, 40);
        res_ready = 1'b0;
        repeat (10) cycle();
        // DONE exit with start high: start must be ignored
        res_ready = 1'b1; start = 1'b1; len = 8'd2;
        cycle();
        start = 1'b0; res_ready = 1'b0;
        cycle(); cycle();

        // len=0 start is ignored; ov_sign_in only outside accumulate cycles
        in_valid = 1'b0; ov_mode = 2;
        start = 1'b1; len = 8'd0;
        cycle();
        start = 1'b0;
        repeat (3) cycle();

        // len=4 with toggling in_valid and a stray start during RUN
        start = 1'b1; len = 8'd4;
        cycle();
        for (int i = 0; i < 40 && m_state == M_RUN; i++) begin
            in_valid = (i % 2 == 0);
            if (i == 3) begin
                start = 1'b1; len = 8'd7;
            end else begin
                start = 1'b0;
            end
            cycle();
        end
        start = 1'b0; in_valid = 1'b0;
        run_until(M_DONE, 40);
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;

        // reset while draining with vld=00110
        ov_mode = 0;
        start = 1'b1; len = 8'd2; in_valid = 1'b1;
        cycle();
        start = 1'b0;
        run_until(M_DRAIN, 10);
        in_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (P + 4) cycle();

        // maximum length job
        start = 1'b1; len = 8'hFF; in_valid = 1'b1;
        cycle();
        start = 1'b0;
        run_until(M_DONE, 400);
        in_valid = 1'b0; res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        cycle(); cycle();

        chk("done_count", rv_rises, done_entries);
        chk("acc_q_empty", acc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_mac_sequencer.md
FP_MAC_SEQUENCER -- requirements
Module: fp_mac_sequencer

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 5: number of MAC pipeline stages sequenced (range 2..8).
REQ-002 SHALL have parameter CNT_W, default 8: width of the vector-length counter.
REQ-003 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin a dot-product job; sampled only in IDLE.
REQ-006 SHALL have port len, input, CNT_W: number of operand pairs in the job; latched on accepted start.
REQ-007 SHALL have port in_valid, input, 1: an operand pair is offered.
REQ-008 SHALL have port in_ready, output, 1: the sequencer accepts an operand pair this cycle.
REQ-009 SHALL have port stage_en, output, PIPE_DEPTH: per-stage register enable for the MAC pipeline.
REQ-010 SHALL have port acc_en, output, 1: accumulator register update enable.
REQ-011 SHALL have port acc_clear, output, 1: accumulator loads the incoming value instead of adding.
REQ-012 SHALL have port ov_sign_in, input, 1: overflow indication from the adder status stage.
REQ-013 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-014 SHALL have port res_valid, output, 1: accumulated result is stable and available.
REQ-015 SHALL have port res_ready, input, 1: the consumer takes the result.
REQ-016 SHALL have port ov_flag, output, 1: sticky overflow for the current job.

Function
REQ-017 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE to RUN SHALL occur on start=1 with len!=0; the sequencer latches len and clears the issued count to 0.
REQ-019 start with len=0 SHALL be ignored, and the state SHALL remain IDLE.
REQ-020 in_ready SHALL be 1 only in RUN while issued<len; accept = in_valid & in_ready.
REQ-021 Each accept SHALL increment issued by 1; RUN to DRAIN SHALL occur on the accept that makes issued equal len.
REQ-022 SHALL keep a valid shift register vld[PIPE_DEPTH-1:0] with vld[0]<=accept and vld[i]<=vld[i-1], so no pipeline bubbles are created internally.
REQ-023 stage_en[0]=accept and stage_en[i]=vld[i-1] for i>=1, both combinational.
REQ-024 acc_en SHALL equal vld[PIPE_DEPTH-1].
REQ-025 SHALL shift a first-tag bit in parallel with vld, set on the first accept of a job; acc_clear SHALL equal acc_en & the tag at the last stage.
REQ-026 DRAIN to DONE SHALL occur when vld is all zero; res_valid SHALL be 1 exactly in DONE.
REQ-027 With the last accept at cycle t, res_valid SHALL first be high at cycle t+PIPE_DEPTH+2.
REQ-028 DONE to IDLE SHALL occur on res_ready=1; res_valid SHALL hold until then.
REQ-029 start SHALL be ignored outside IDLE, including in the DONE-exit cycle.
REQ-030 in_valid SHALL be ignored outside RUN.
REQ-031 res_ready SHALL be ignored outside DONE.
REQ-032 issued SHALL never wrap, because acceptance stops at len; len=2^CNT_W-1 SHALL be supported.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE with issued=0, vld=0, tag=0 and ov_flag=0.
REQ-034 During and after reset, in_ready, stage_en, acc_en, acc_clear, busy and res_valid SHALL be 0.
REQ-035 reset mid-job SHALL abandon the job and discard in-flight tags; the first post-reset cycle SHALL behave as IDLE.

Configuration
REQ-036 The macro FP_MAC_SEQ_OVF_FLAG_EN, when defined, SHALL set ov_flag when acc_en & ov_sign_in, clear it on the start that begins a job, and hold it through DONE.
REQ-037 When FP_MAC_SEQ_OVF_FLAG_EN is undefined, ov_flag SHALL be constant 0, ov_sign_in SHALL be unused, and the port list SHALL be unchanged.

Verification
REQ-038 Reset, then start with len=3 and in_valid held 1 -> accepts at cycles 1..3, acc_clear only on the first acc_en, res_valid at last accept+7 (PIPE_DEPTH=5).
REQ-039 len=4 with in_valid toggling 1,0,1,0... -> exactly 4 accepts, acc_en pulses spaced 2 cycles apart, DONE reached once.
REQ-040 start with len=0 -> busy stays 0; a later start while in RUN -> len and the issued count are unchanged.
REQ-041 res_ready held 0 for 10 cycles in DONE -> res_valid stays 1; res_ready=1 -> IDLE next cycle, and a new job's ov_flag clears.
REQ-042 reset asserted in DRAIN with vld=5'b00110 -> the next cycle has all outputs 0 and the state is IDLE; no acc_en follows.
REQ-043 With the macro, ov_sign_in=1 on the 2nd of 3 acc_en pulses -> ov_flag=1 through DONE; without the macro -> ov_flag=0.
